// File: rtl/ped_crossing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ped_crossing_pkg
// Brief    : State codes, lamp vector type and lamp decode for ped_crossing_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package ped_crossing_pkg;

    typedef enum logic [2:0] {
        ROAD_GO  = 3'd0,
        ROAD_YEL = 3'd1,
        CLR1     = 3'd2,
        WALK     = 3'd3,
        FLASH    = 3'd4,
        CLR2     = 3'd5
    } state_t;

    typedef struct packed {
        logic road_red;
        logic road_yellow;
        logic road_green;
        logic ped_red;
        logic ped_green;
    } lamps_t;

    // Anything not explicitly a traffic or walk phase shows all-red.
    function automatic lamps_t decode_lamps(input state_t st, input logic flash_on);
        lamps_t l;
        l = '0;
        case (st)
            ROAD_GO: begin
                l.road_green = 1'b1;
                l.ped_red    = 1'b1;
            end
            ROAD_YEL: begin
                l.road_yellow = 1'b1;
                l.ped_red     = 1'b1;
            end
            WALK: begin
                l.road_red  = 1'b1;
                l.ped_green = 1'b1;
            end
            FLASH: begin
                l.road_red  = 1'b1;
                l.ped_green = flash_on;
            end
            default: begin
                l.road_red = 1'b1;
                l.ped_red  = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_crossing_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for a single asynchronous level input
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ped_crossing_ctrl
// Brief    : Demand-driven pedestrian crossing sequencer with registered lamps
// Revision : 1.0 - initial release
// ============================================================================
module ped_crossing_ctrl
    import ped_crossing_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 10,
    parameter int T_GREEN_MAX = 60,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int T_WALK      = 8,
    parameter int T_FLASH     = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ROAD_DET,
    input  logic       PED_BUTT,
    output logic       ROAD_RED,
    output logic       ROAD_YELLOW,
    output logic       ROAD_GREEN,
    output logic       PED_RED,
    output logic       PED_GREEN,
    output logic       PED_WAIT,
    output logic [2:0] STATE
);

    localparam int               PRE_W        = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] GREEN_MIN    = CNT_W'(T_GREEN_MIN);
    localparam logic [CNT_W-1:0] GREEN_MAX    = CNT_W'(T_GREEN_MAX);
    localparam logic [CNT_W-1:0] YELLOW_TICKS = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] ALLRED_TICKS = CNT_W'(T_ALL_RED);
    localparam logic [CNT_W-1:0] WALK_TICKS   = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] FLASH_TICKS  = CNT_W'(T_FLASH);

    generate
        if (TICK_DIV < 2 || T_GREEN_MAX < T_GREEN_MIN) begin : g_bad_params
            $error("ped_crossing_ctrl: TICK_DIV must be >= 2 and T_GREEN_MAX >= T_GREEN_MIN");
        end
    endgenerate

    logic             det_s;
    logic             butt_s;
    logic             butt_prev;
    logic             butt_rise;
    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_next;
    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_done;
    logic [CNT_W-1:0] cnt_next;
    state_t           state;
    state_t           next_state;
    logic             entering;
    logic             req;
    lamps_t           lamps;

    sync_2ff u_sync_det (
        .clk   (CLK),
        .rst_n (nRST),
        .d     (ROAD_DET),
        .q     (det_s)
    );

    sync_2ff u_sync_butt (
        .clk   (CLK),
        .rst_n (nRST),
        .d     (PED_BUTT),
        .q     (butt_s)
    );

    assign butt_rise = butt_s & ~butt_prev;

    // cnt_done counts ticks completed by the end of this cycle, so a phase of
    // N ticks leaves on the very cycle its N-th tick completes.
    always_comb begin
        tick       = (presc == PRE_LAST);
        cnt_done   = (tick && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
        cnt_next   = entering ? '0 : cnt_done;
        presc_next = (entering || tick) ? '0 : presc + PRE_W'(1);
    end

    always_comb begin
        next_state = state;
        case (state)
            ROAD_GO: begin
                if (req && (cnt_done >= GREEN_MIN) && (!det_s || (cnt_done >= GREEN_MAX)))
                    next_state = ROAD_YEL;
            end
            ROAD_YEL: begin
                if (tick && (cnt_done == YELLOW_TICKS))
                    next_state = CLR1;
            end
            CLR1: begin
                if (tick && (cnt_done == ALLRED_TICKS))
                    next_state = WALK;
            end
            WALK: begin
                if (tick && (cnt_done == WALK_TICKS))
                    next_state = FLASH;
            end
            FLASH: begin
                if (tick && (cnt_done == FLASH_TICKS))
                    next_state = CLR2;
            end
            CLR2: begin
                if (tick && (cnt_done == ALLRED_TICKS))
                    next_state = ROAD_GO;
            end
            default: next_state = CLR2;
        endcase
    end

    assign entering = (next_state != state);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= CLR2;
            presc     <= '0;
            cnt       <= '0;
            butt_prev <= 1'b0;
        end else begin
            state     <= next_state;
            presc     <= presc_next;
            cnt       <= cnt_next;
            butt_prev <= butt_s;
        end
    end

    // Entry to WALK serves the request, so its clear outranks a same-cycle press.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req <= 1'b0;
        end else if (entering && (next_state == WALK)) begin
            req <= 1'b0;
        end else if (butt_rise && (state != WALK) && (state != FLASH)) begin
            req <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lamps <= decode_lamps(CLR2, 1'b0);
        end else begin
            lamps <= decode_lamps(next_state, ~cnt_next[0]);
        end
    end

    assign ROAD_RED    = lamps.road_red;
    assign ROAD_YELLOW = lamps.road_yellow;
    assign ROAD_GREEN  = lamps.road_green;
    assign PED_RED     = lamps.ped_red;
    assign PED_GREEN   = lamps.ped_green;
    assign PED_WAIT    = req;
    assign STATE       = state;

endmodule
`default_nettype wire

// File: tb/tb_ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ped_crossing_ctrl
// Brief    : Self-checking bench for ped_crossing_ctrl against a cycle-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ped_crossing_ctrl;

    localparam int TD   = 4;
    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int TY   = 2;
    localparam int TAR  = 1;
    localparam int TW   = 2;
    localparam int TF   = 2;

    localparam int P_GO = 0, P_YEL = 1, P_CLR1 = 2, P_WALK = 3, P_FLASH = 4, P_CLR2 = 5;

    // {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN}
    localparam logic [4:0] L_CLR  = 5'b10010;
    localparam logic [4:0] L_GRN  = 5'b00110;
    localparam logic [4:0] L_YEL  = 5'b01010;
    localparam logic [4:0] L_WALK = 5'b10001;
    localparam logic [4:0] L_FOFF = 5'b10000;
    localparam logic [8:0] RESET_VEC = {3'd5, L_CLR, 1'b0};

    logic       CLK      = 1'b0;
    logic       nRST     = 1'b1;
    logic       ROAD_DET = 1'b0;
    logic       PED_BUTT = 1'b0;
    logic       ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN, PED_WAIT;
    logic [2:0] STATE;

    wire [4:0] lamps_obs = {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN};
    wire [8:0] dut_vec   = {STATE, lamps_obs, PED_WAIT};

    int n_cmp  = 0;
    int n_fail = 0;

    int m_phase;
    int m_elapsed;
    bit m_req, m_d1, m_d2, m_b1, m_b2, m_bp;

    logic [8:0] hist_d [0:255];
    logic [8:0] hist_m [0:255];
    logic       hist_w [0:255];

    always #5 CLK = ~CLK;

    ped_crossing_ctrl #(
        .TICK_DIV    (TD),
        .CNT_W       (8),
        .T_GREEN_MIN (GMIN),
        .T_GREEN_MAX (GMAX),
        .T_YELLOW    (TY),
        .T_ALL_RED   (TAR),
        .T_WALK      (TW),
        .T_FLASH     (TF)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ROAD_DET    (ROAD_DET),
        .PED_BUTT    (PED_BUTT),
        .ROAD_RED    (ROAD_RED),
        .ROAD_YELLOW (ROAD_YELLOW),
        .ROAD_GREEN  (ROAD_GREEN),
        .PED_RED     (PED_RED),
        .PED_GREEN   (PED_GREEN),
        .PED_WAIT    (PED_WAIT),
        .STATE       (STATE)
    );

    // Reference model: phases measured in plain clock cycles.
    function automatic int phase_len(input int p);
        case (p)
            P_YEL:          return TY * TD;
            P_CLR1, P_CLR2: return TAR * TD;
            P_WALK:         return TW * TD;
            P_FLASH:        return TF * TD;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [8:0] model_out();
        logic [4:0] l;
        case (m_phase)
            P_GO:    l = L_GRN;
            P_YEL:   l = L_YEL;
            P_WALK:  l = L_WALK;
            P_FLASH: l = (((m_elapsed / TD) % 2) == 0) ? L_WALK : L_FOFF;
            default: l = L_CLR;
        endcase
        return {3'(m_phase), l, m_req};
    endfunction

    task automatic model_reset();
        m_phase = P_CLR2; m_elapsed = 0; m_req = 1'b0;
        m_d1 = 1'b0; m_d2 = 1'b0; m_b1 = 1'b0; m_b2 = 1'b0; m_bp = 1'b0;
    endtask

    task automatic model_edge(input bit det, input bit butt);
        bit det_s, rise, leave;
        int ne;
        det_s = m_d2;
        rise  = m_b2 && !m_bp;
        ne    = m_elapsed + 1;
        if (m_phase == P_GO)
            leave = m_req && (ne >= GMIN * TD) && (!det_s || (ne >= GMAX * TD));
        else
            leave = (ne == phase_len(m_phase));
        if (leave && m_phase == P_CLR1)
            m_req = 1'b0;
        else if (rise && m_phase != P_WALK && m_phase != P_FLASH)
            m_req = 1'b1;
        if (leave) begin
            m_phase   = (m_phase + 1) % 6;
            m_elapsed = 0;
        end else begin
            m_elapsed = ne;
        end
        m_bp = m_b2; m_b2 = m_b1; m_b1 = butt;
        m_d2 = m_d1; m_d1 = det;
    endtask

    task automatic step(input bit det, input bit butt);
        ROAD_DET = det;
        PED_BUTT = butt;
        @(posedge CLK);
        if (nRST) model_edge(det, butt);
        else      model_reset();
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        nRST = 1'b0;
        model_reset();
        repeat (cycles) step(1'b0, 1'b0);
        nRST = 1'b1;
    endtask

    // Fresh reset, then record ncyc cycles with up to two button presses.
    task automatic run_seq(input bit det, input int p1, input int p2, input int ncyc);
        bit butt;
        apply_reset(2);
        for (int k = 0; k < ncyc; k++) begin
            hist_d[k] = dut_vec;
            hist_m[k] = model_out();
            hist_w[k] = PED_WAIT;
            butt = (k >= p1 && k < p1 + 4) || (k >= p2 && k < p2 + 3);
            step(det, butt);
        end
    endtask

    task automatic test_reset();
        logic [4:0] exp_l;
        #1;
        nRST = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", dut_vec, RESET_VEC);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int k = 0; k < 204; k++) begin
            exp_l = (k < TAR * TD) ? L_CLR : L_GRN;
            n_cmp++;
            if (lamps_obs !== exp_l) begin
                n_fail++;
                $display("FAIL reset_release_lamps cycle %0d: got %b expected %b", k, lamps_obs, exp_l);
            end
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_fail++;
                $display("FAIL reset_release_model cycle %0d: got %b expected %b", k, dut_vec, model_out());
            end
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_crossing(input bit det);
        int glen, ncyc, seg, len, w0;
        logic [7:0] tv [0:8];
        int         tl [0:8];
        glen = det ? GMAX * TD : GMIN * TD;
        ncyc = glen + 50;
        tv = '{{3'd5, L_CLR}, {3'd0, L_GRN}, {3'd1, L_YEL}, {3'd2, L_CLR}, {3'd3, L_WALK},
               {3'd4, L_WALK}, {3'd4, L_FOFF}, {3'd5, L_CLR}, {3'd0, L_GRN}};
        tl = '{4, glen, 8, 4, 8, 4, 4, 4, 0};
        run_seq(det, 5, -100, ncyc);
        for (int k = 0; k < ncyc; k++) begin
            n_cmp++;
            if (hist_d[k] !== hist_m[k]) begin
                n_fail++;
                $display("FAIL crossing_model det=%0d cycle %0d: got %b expected %b", det, k, hist_d[k], hist_m[k]);
            end
        end
        n_cmp++;
        if ({hist_w[6], hist_w[7], hist_w[8]} !== 3'b001) begin
            n_fail++;
            $display("FAIL button_latency det=%0d: got %b expected 001", det, {hist_w[6], hist_w[7], hist_w[8]});
        end
        w0 = 4 + glen + 12;
        n_cmp++;
        if ({hist_w[w0 - 1], hist_w[w0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL wait_clear_on_walk det=%0d: got %b expected 10", det, {hist_w[w0 - 1], hist_w[w0]});
        end
        seg = 0;
        len = 1;
        for (int k = 1; k < ncyc; k++) begin
            if (hist_d[k][8:1] === hist_d[k - 1][8:1]) begin
                len++;
            end else begin
                if (seg < 9) begin
                    n_cmp++;
                    if (hist_d[k - 1][8:1] !== tv[seg] || (tl[seg] != 0 && len != tl[seg])) begin
                        n_fail++;
                        $display("FAIL segment_%0d det=%0d: got %b x%0d expected %b x%0d",
                                 seg, det, hist_d[k - 1][8:1], len, tv[seg], tl[seg]);
                    end
                end
                seg++;
                len = 1;
            end
        end
        n_cmp++;
        if (seg != 8 || hist_d[ncyc - 1][8:1] !== tv[8]) begin
            n_fail++;
            $display("FAIL segment_count det=%0d: got %0d ending %b expected 8 ending %b",
                     det, seg, hist_d[ncyc - 1][8:1], tv[8]);
        end
    endtask

    task automatic test_press_walk();
        run_seq(1'b0, 5, 30, 160);
        for (int k = 0; k < 160; k++) begin
            n_cmp++;
            if (hist_d[k] !== hist_m[k]) begin
                n_fail++;
                $display("FAIL walk_press_model cycle %0d: got %b expected %b", k, hist_d[k], hist_m[k]);
            end
            if (k >= 28 && k < 48) begin
                n_cmp++;
                if (hist_w[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL walk_press_ignored cycle %0d: got %b expected 0", k, hist_w[k]);
                end
            end
            if (k >= 48) begin
                n_cmp++;
                if (hist_d[k] !== {3'd0, L_GRN, 1'b0}) begin
                    n_fail++;
                    $display("FAIL walk_press_hold_green cycle %0d: got %b expected %b", k, hist_d[k], {3'd0, L_GRN, 1'b0});
                end
            end
        end
    endtask

    task automatic test_reset_mid_phase();
        logic [4:0] exp_l;
        run_seq(1'b0, 5, -100, 10);
        n_cmp++;
        if (PED_WAIT !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_req_before_reset: got %b expected 1", PED_WAIT);
        end
        nRST = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_clears_req: got %b expected %b", dut_vec, RESET_VEC);
        end
        step(1'b0, 1'b0);
        nRST = 1'b1;
        run_seq(1'b0, 5, -100, 31);
        n_cmp++;
        if (dut_vec !== {3'd3, L_WALK, 1'b0}) begin
            n_fail++;
            $display("FAIL in_walk_before_reset: got %b expected %b", dut_vec, {3'd3, L_WALK, 1'b0});
        end
        nRST = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_mid_walk: got %b expected %b", dut_vec, RESET_VEC);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        nRST = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_l = (k < TAR * TD) ? L_CLR : L_GRN;
            n_cmp++;
            if (lamps_obs !== exp_l) begin
                n_fail++;
                $display("FAIL resume_after_reset cycle %0d: got %b expected %b", k, lamps_obs, exp_l);
            end
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        bit det;
        bit butt;
        int hold;
        det  = 1'b0;
        hold = 0;
        apply_reset(2);
        for (int k = 0; k < 4000; k++) begin
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %b expected %b", k, dut_vec, model_out());
            end
            if ($urandom_range(0, 29) == 0) det = ~det;
            if (hold > 0) hold--;
            else if ($urandom_range(0, 24) == 0) hold = int'($urandom_range(1, 6));
            butt = (hold > 0);
            if ($urandom_range(0, 899) == 0) begin
                nRST = 1'b0;
                model_reset();
                #1;
                n_cmp++;
                if (dut_vec !== RESET_VEC) begin
                    n_fail++;
                    $display("FAIL random_reset cycle %0d: got %b expected %b", k, dut_vec, RESET_VEC);
                end
                repeat ($urandom_range(1, 3)) step(det, butt);
                nRST = 1'b1;
            end else begin
                step(det, butt);
            end
        end
    endtask

    initial begin
        model_reset();
        fork
            forever begin
                @(negedge CLK);
                if (nRST === 1'b1 || nRST === 1'b0) begin
                    n_cmp++;
                    if (ROAD_GREEN === 1'b1 && PED_GREEN === 1'b1) begin
                        n_fail++;
                        $display("FAIL invariant_green_conflict at %0t: got RG=%b PG=%b expected not both 1",
                                 $time, ROAD_GREEN, PED_GREEN);
                    end
                    n_cmp++;
                    if (!$onehot({ROAD_RED, ROAD_YELLOW, ROAD_GREEN})) begin
                        n_fail++;
                        $display("FAIL invariant_road_onehot at %0t: got %b expected one-hot",
                                 $time, {ROAD_RED, ROAD_YELLOW, ROAD_GREEN});
                    end
                end
            end
        join_none
        test_reset();
        test_crossing(1'b0);
        test_crossing(1'b1);
        test_press_walk();
        test_reset_mid_phase();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
